// File: rtl/fifo_buffer.sv
// fifo_buffer: single-clock FIFO of 16-bit flits with registered read data and
// empty/full flags decoded from the occupancy count.
module fifo_buffer #(
  parameter int n = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RD,
  input  logic        WR,
  input  logic [15:0] data,
  output logic [15:0] out,
  output logic        emp,
  output logic        full
);
  localparam int pw = $clog2(n);
  localparam int cw = $clog2(n + 1);
  logic [15:0]   mem [n];
  logic [pw-1:0] wptr, rptr;
  logic [cw-1:0] cnt;
  logic          wa, ra;
  assign emp  = cnt == '0;
  assign full = cnt == cw'(n);
  assign wa   = WR && !full;
  assign ra   = RD && !emp;
  // Storage has no reset so it can map onto RAM; stale entries are never read.
  always_ff @(posedge clk)
    if (wa) mem[wptr] <= data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      out  <= '0;
    end else begin
      if (wa) wptr <= (wptr == pw'(n - 1)) ? '0 : wptr + pw'(1);
      if (ra) begin
        out  <= mem[rptr];
        rptr <= (rptr == pw'(n - 1)) ? '0 : rptr + pw'(1);
      end
      cnt <= cnt + cw'(wa) - cw'(ra);
    end
endmodule

// File: tb/tb_fifo_buffer.sv
// tb_fifo_buffer: scoreboard bench for fifo_buffer at depths 4 and 5.
module tb_fifo_buffer;
  logic        clk = 1'b0, rst_n = 1'b0, rd = 1'b0, wr = 1'b0, sel = 1'b0;
  logic [15:0] din = '0, out_a, out_b, exp_out = '0;
  logic        emp_a, emp_b, full_a, full_b;
  logic [15:0] mq[$], eq[$];
  int tests = 0, failed = 0;

  always #5 clk = ~clk;

  fifo_buffer #(.n(4)) u_a (.clk(clk), .rst_n(rst_n), .RD(rd & ~sel), .WR(wr & ~sel),
    .data(din), .out(out_a), .emp(emp_a), .full(full_a));
  fifo_buffer #(.n(5)) u_b (.clk(clk), .rst_n(rst_n), .RD(rd & sel), .WR(wr & sel),
    .data(din), .out(out_b), .emp(emp_b), .full(full_b));

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [15:0] d);
    int  cap = sel ? 5 : 4;
    bit  ra, wa;
    @(negedge clk);
    rd = r; wr = w; din = d;
    ra = r && mq.size() > 0;
    wa = w && mq.size() < cap;
    if (ra) eq.push_back(mq.pop_front());
    if (wa) mq.push_back(d);
    @(posedge clk);
    #1;
    if (eq.size() > 0) exp_out = eq.pop_front();
    chk("out",  sel ? out_b : out_a, exp_out);
    chk("emp",  16'(sel ? emp_b : emp_a), 16'(mq.size() == 0));
    chk("full", 16'(sel ? full_b : full_a), 16'(mq.size() == cap));
    chk("cnt",  sel ? 16'(u_b.cnt) : 16'(u_a.cnt), 16'(mq.size()));
    rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_out", out_a, 16'h0000);
    chk("rst_emp", 16'(emp_a), 16'd1);
    chk("rst_full", 16'(full_a), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // fill and overflow
    step(0, 1, 16'h0020); step(0, 1, 16'h0127); step(0, 1, 16'h0032);
    step(0, 1, 16'h0763); step(0, 1, 16'h0098);
    // drain and underflow
    for (int i = 0; i < 6; i++) step(1, 0, 16'h0);
    // wrap-around
    for (int i = 1; i <= 3; i++) step(0, 1, 16'(i));
    step(1, 0, 16'h0); step(1, 0, 16'h0);
    for (int i = 4; i <= 6; i++) step(0, 1, 16'(i));
    for (int i = 0; i < 4; i++) step(1, 0, 16'h0);
    // simultaneous read and write: empty, streaming, full
    step(1, 1, 16'h0010);
    step(0, 1, 16'h0011);
    for (int i = 0; i < 10; i++) step(1, 1, 16'h0100 + 16'(i));
    step(0, 1, 16'h0180); step(0, 1, 16'h0181);
    step(1, 1, 16'h0200);
    for (int i = 0; i < 4; i++) step(1, 0, 16'h0);
    // asynchronous reset with entries queued
    step(0, 1, 16'h0301); step(0, 1, 16'h0302); step(1, 0, 16'h0);
    step(0, 1, 16'h0303); step(0, 1, 16'h0304);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out", out_a, 16'h0000);
    chk("arst_emp", 16'(emp_a), 16'd1);
    chk("arst_full", 16'(full_a), 16'd0);
    mq.delete(); eq.delete(); exp_out = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 16'h00AA);
    step(1, 0, 16'h0);
    chk("post_rst_out", out_a, 16'h00AA);
    // depth 5 instance
    sel = 1'b1; mq.delete(); eq.delete(); exp_out = '0;
    for (int i = 0; i < 6; i++) step(0, 1, 16'h0500 + 16'(i));
    for (int i = 0; i < 6; i++) step(1, 0, 16'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
